// File: rtl/adma_pkg.sv
// adma_pkg: shared burst encodings, 4KB constant and burst-generator FSM states
package adma_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int AXI_4KB = 4096;
  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} adma_state_e;
endpackage

// File: rtl/adma_dm_burst_calc.sv
// adma_dm_burst_calc: beats of the next burst = min(remaining, 2^ATX_LEN_W, FIXED/4KB limit)
module adma_dm_burst_calc
  import adma_pkg::*;
#(
  parameter int ATX_LEN_W = 8,
  parameter int BYTE_AMT = 32,
  parameter int REM_W = 16,
  parameter bit NO_4K = 1'b0
) (
  input  logic [REM_W-1:0]   remaining,
  input  logic [11:0]        addr_lo,
  input  logic [1:0]         burst,
  output logic [ATX_LEN_W:0] n
);
  localparam int MAX = 1 << ATX_LEN_W;
  localparam int SH = $clog2(BYTE_AMT);
  localparam int NW = ATX_LEN_W + 1;
  logic [31:0] rem_w, lim, cap;
  always_comb begin
    rem_w = 32'(remaining);
    lim = (burst == BURST_FIXED) ? 32'd16 : NO_4K ? 32'(MAX) : (32'(AXI_4KB) - 32'(addr_lo)) >> SH;
    cap = (lim < 32'(MAX)) ? lim : 32'(MAX);
    n = NW'((rem_w < cap) ? rem_w : cap);
  end
endmodule

// File: rtl/adma_dm_wr_atx_gen.sv
// adma_dm_wr_atx_gen: splits write descriptors into legal AXI bursts for the write host
module adma_dm_wr_atx_gen
  import adma_pkg::*;
#(
  parameter int DMA_CHN_NUM = 4,
  parameter DST_IF_TYPE = "AXI4",
  parameter int DST_ADDR_W = 32,
  parameter int MST_ID_W = 5,
  parameter int ATX_LEN_W = 8,
  parameter int ATX_DST_DATA_W = 256,
  parameter int DESC_BEAT_W = 16,
  parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_CHN_NUM_W-1:0] desc_chn_id,
  input  logic [DST_ADDR_W-1:0]    desc_addr,
  input  logic [DESC_BEAT_W-1:0]   desc_beats,
  input  logic [1:0]               desc_burst,
  input  logic                     desc_vld,
  output logic                     desc_rdy,
  input  logic [MST_ID_W-1:0]      atx_id [0:DMA_CHN_NUM-1],
  output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  output logic [MST_ID_W-1:0]      atx_awid,
  output logic [DST_ADDR_W-1:0]    atx_awaddr,
  output logic [ATX_LEN_W-1:0]     atx_awlen,
  output logic [1:0]               atx_awburst,
  output logic                     atx_vld,
  input  logic                     atx_rdy,
  output logic                     desc_done,
  output logic [DMA_CHN_NUM_W-1:0] desc_done_chn_id,
  output logic                     busy
);
  localparam int BYTE_AMT = ATX_DST_DATA_W / 8;
  localparam int SH = $clog2(BYTE_AMT);
  localparam bit NO_4K = (DST_IF_TYPE == "AXIS");
  localparam logic [ATX_LEN_W:0] ONE = 1;
  adma_state_e state_q, state_d;
  logic [DMA_CHN_NUM_W-1:0] chn_q, chn_d, done_chn_q, done_chn_d;
  logic [DST_ADDR_W-1:0] addr_q, addr_d, awaddr_q, awaddr_d;
  logic [DESC_BEAT_W-1:0] rem_q, rem_d;
  logic [1:0] burst_q, burst_d;
  logic [MST_ID_W-1:0] awid_q, awid_d;
  logic [ATX_LEN_W-1:0] awlen_q, awlen_d;
  logic rdy_q, rdy_d, vld_q, vld_d, done_q, done_d, busy_q, busy_d;
  logic [ATX_LEN_W:0] n_calc, n_iss;

  adma_dm_burst_calc #(
    .ATX_LEN_W(ATX_LEN_W),
    .BYTE_AMT (BYTE_AMT),
    .REM_W    (DESC_BEAT_W),
    .NO_4K    (NO_4K)
  ) u_calc (
    .remaining(rem_q),
    .addr_lo  (addr_q[11:0]),
    .burst    (burst_q),
    .n        (n_calc)
  );

  assign n_iss = {1'b0, awlen_q} + ONE;

  always_comb begin
    state_d = state_q;
    chn_d = chn_q;
    addr_d = addr_q;
    rem_d = rem_q;
    burst_d = burst_q;
    awid_d = awid_q;
    awaddr_d = awaddr_q;
    awlen_d = awlen_q;
    case (state_q)
      IDLE: if (desc_vld) begin
        chn_d = desc_chn_id;
        addr_d = desc_addr & ~DST_ADDR_W'(BYTE_AMT - 1);
        rem_d = desc_beats;
        burst_d = desc_burst;
        awid_d = atx_id[desc_chn_id];
        state_d = (desc_beats == '0) ? DONE : CALC;
      end
      CALC: begin
        awaddr_d = addr_q;
        awlen_d = ATX_LEN_W'(n_calc - ONE);
        state_d = ISSUE;
      end
      ISSUE: if (atx_rdy) begin
        rem_d = rem_q - DESC_BEAT_W'(n_iss);
        addr_d = (burst_q == BURST_INCR) ? addr_q + (DST_ADDR_W'(n_iss) << SH) : addr_q;
        state_d = (rem_d == '0) ? DONE : CALC;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE;
    vld_d = state_d == ISSUE;
    done_d = state_d == DONE;
    busy_d = (state_d == CALC) || (state_d == ISSUE);
    done_chn_d = (state_d == DONE) ? chn_d : done_chn_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chn_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      burst_q <= '0;
      awid_q <= '0;
      awaddr_q <= '0;
      awlen_q <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      done_chn_q <= '0;
    end else begin
      state_q <= state_d;
      chn_q <= chn_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      burst_q <= burst_d;
      awid_q <= awid_d;
      awaddr_q <= awaddr_d;
      awlen_q <= awlen_d;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
      done_q <= done_d;
      busy_q <= busy_d;
      done_chn_q <= done_chn_d;
    end
  end

  assign desc_rdy = rdy_q;
  assign atx_chn_id = chn_q;
  assign atx_awid = awid_q;
  assign atx_awaddr = awaddr_q;
  assign atx_awlen = awlen_q;
  assign atx_awburst = burst_q;
  assign atx_vld = vld_q;
  assign desc_done = done_q;
  assign desc_done_chn_id = done_chn_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_adma_dm_wr_atx_gen.sv
// tb_adma_dm_wr_atx_gen: table-driven directed checks of burst splitting, backpressure and reset abort
module tb_adma_dm_wr_atx_gen;
  typedef struct {
    bit axis;
    int chn;
    logic [31:0] addr;
    int beats;
    logic [1:0] burst;
    int nb;
    int stall;
    logic [0:4][31:0] ea;
    logic [0:4][7:0] el;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [1:0] desc_chn_id = '0;
  logic [31:0] desc_addr = '0;
  logic [15:0] desc_beats = '0;
  logic [1:0] desc_burst = '0;
  logic desc_vld = 1'b0;
  logic atx_rdy = 1'b0;
  logic [4:0] atx_id [0:3];
  logic a_rdy, b_rdy, a_vld, b_vld, a_done, b_done, a_busy, b_busy;
  logic [1:0] a_chn, b_chn, a_dchn, b_dchn, a_burst, b_burst;
  logic [4:0] a_awid, b_awid;
  logic [31:0] a_awaddr, b_awaddr;
  logic [7:0] a_awlen, b_awlen;
  logic o_rdy, o_vld, o_done, o_busy;
  logic [1:0] o_chn, o_dchn, o_burst;
  logic [4:0] o_awid;
  logic [31:0] o_awaddr;
  logic [7:0] o_awlen;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  adma_dm_wr_atx_gen #(.DST_IF_TYPE("AXI4")) u_axi (
    .clk(clk), .rst(rst), .desc_chn_id(desc_chn_id), .desc_addr(desc_addr), .desc_beats(desc_beats),
    .desc_burst(desc_burst), .desc_vld(desc_vld && !sel), .desc_rdy(a_rdy), .atx_id(atx_id),
    .atx_chn_id(a_chn), .atx_awid(a_awid), .atx_awaddr(a_awaddr), .atx_awlen(a_awlen),
    .atx_awburst(a_burst), .atx_vld(a_vld), .atx_rdy(atx_rdy), .desc_done(a_done),
    .desc_done_chn_id(a_dchn), .busy(a_busy)
  );

  adma_dm_wr_atx_gen #(.DST_IF_TYPE("AXIS")) u_axis (
    .clk(clk), .rst(rst), .desc_chn_id(desc_chn_id), .desc_addr(desc_addr), .desc_beats(desc_beats),
    .desc_burst(desc_burst), .desc_vld(desc_vld && sel), .desc_rdy(b_rdy), .atx_id(atx_id),
    .atx_chn_id(b_chn), .atx_awid(b_awid), .atx_awaddr(b_awaddr), .atx_awlen(b_awlen),
    .atx_awburst(b_burst), .atx_vld(b_vld), .atx_rdy(atx_rdy), .desc_done(b_done),
    .desc_done_chn_id(b_dchn), .busy(b_busy)
  );

  assign o_rdy = sel ? b_rdy : a_rdy;
  assign o_vld = sel ? b_vld : a_vld;
  assign o_done = sel ? b_done : a_done;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_chn = sel ? b_chn : a_chn;
  assign o_dchn = sel ? b_dchn : a_dchn;
  assign o_burst = sel ? b_burst : a_burst;
  assign o_awid = sel ? b_awid : a_awid;
  assign o_awaddr = sel ? b_awaddr : a_awaddr;
  assign o_awlen = sel ? b_awlen : a_awlen;

  assert property (@(posedge clk) disable iff (rst)
    (o_vld && !atx_rdy) |=> (o_vld && $stable(o_awaddr) && $stable(o_awlen) && $stable(o_awid) && $stable(o_chn)))
  else begin
    n_fail++;
    $display("FAIL bp_stable: burst fields changed or atx_vld dropped without atx_rdy");
  end

  assert property (@(posedge clk) disable iff (rst)
    (desc_vld && o_rdy && desc_beats == 16'd0) |=> (o_done && !o_vld))
  else begin
    n_fail++;
    $display("FAIL zero_beat: desc_done=%0b atx_vld=%0b required 1/0", o_done, o_vld);
  end

  function automatic vec_t mk(input bit axis, input int chn, input logic [31:0] addr, input int beats,
                              input logic [1:0] burst, input int nb, input int stall,
                              input logic [0:4][31:0] ea, input logic [0:4][7:0] el);
    vec_t v;
    v.axis = axis;
    v.chn = chn;
    v.addr = addr;
    v.beats = beats;
    v.burst = burst;
    v.nb = nb;
    v.stall = stall;
    v.ea = ea;
    v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int t;
    sel = v.axis;
    @(negedge clk);
    chk("desc_rdy", 64'(o_rdy), 64'd1);
    desc_chn_id = 2'(v.chn);
    desc_addr = v.addr;
    desc_beats = 16'(v.beats);
    desc_burst = v.burst;
    desc_vld = 1'b1;
    @(negedge clk);
    desc_vld = 1'b0;
    if (v.nb == 0) begin
      chk("zero_done", 64'(o_done), 64'd1);
      chk("zero_done_chn", 64'(o_dchn), 64'(v.chn));
      chk("zero_vld", 64'(o_vld), 64'd0);
      chk("zero_busy", 64'(o_busy), 64'd0);
    end else begin
      chk("busy", 64'(o_busy), 64'd1);
      chk("calc_vld", 64'(o_vld), 64'd0);
      for (int b = 0; b < v.nb; b++) begin
        t = 0;
        while (!o_vld && t < 8) begin
          @(negedge clk);
          t++;
        end
        chk("vld_latency", 64'(t), 64'd1);
        chk("awaddr", 64'(o_awaddr), 64'(v.ea[b]));
        chk("awlen", 64'(o_awlen), 64'(v.el[b]));
        chk("awid", 64'(o_awid), 64'(atx_id[v.chn]));
        chk("atx_chn", 64'(o_chn), 64'(v.chn));
        chk("awburst", 64'(o_burst), 64'(v.burst));
        for (int s = 0; s < v.stall; s++) begin
          @(negedge clk);
          chk("stall_vld", 64'(o_vld), 64'd1);
          chk("stall_awaddr", 64'(o_awaddr), 64'(v.ea[b]));
          chk("stall_awlen", 64'(o_awlen), 64'(v.el[b]));
        end
        atx_rdy = 1'b1;
        @(negedge clk);
        atx_rdy = 1'b0;
        chk("post_hs_vld", 64'(o_vld), 64'd0);
        chk("done_pulse", 64'(o_done), 64'(b == v.nb - 1));
      end
      chk("done_chn", 64'(o_dchn), 64'(v.chn));
    end
    @(negedge clk);
    chk("done_clear", 64'(o_done), 64'd0);
    chk("idle_rdy", 64'(o_rdy), 64'd1);
    chk("idle_busy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 4; i++) atx_id[i] = 5'(5'h11 + 3 * i);
    vecs[0] = mk(0, 1, 32'h0000_1000, 4, 2'b01, 1, 0, {32'h1000, 32'h0, 32'h0, 32'h0, 32'h0}, {8'd3, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[1] = mk(0, 2, 32'h0000_0FC0, 8, 2'b01, 2, 0, {32'h0FC0, 32'h1000, 32'h0, 32'h0, 32'h0}, {8'd1, 8'd5, 8'd0, 8'd0, 8'd0});
    vecs[2] = mk(0, 0, 32'h0000_0000, 600, 2'b01, 5, 0, {32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h4000}, {8'd127, 8'd127, 8'd127, 8'd127, 8'd87});
    vecs[3] = mk(0, 3, 32'h0000_2000, 40, 2'b00, 3, 5, {32'h2000, 32'h2000, 32'h2000, 32'h0, 32'h0}, {8'd15, 8'd15, 8'd7, 8'd0, 8'd0});
    vecs[4] = mk(1, 1, 32'h0000_0FC0, 8, 2'b01, 1, 0, {32'h0FC0, 32'h0, 32'h0, 32'h0, 32'h0}, {8'd7, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[5] = mk(0, 2, 32'h0000_1234, 0, 2'b01, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[6] = mk(0, 1, 32'h0000_1FF5, 3, 2'b01, 2, 1, {32'h1FE0, 32'h2000, 32'h0, 32'h0, 32'h0}, {8'd0, 8'd1, 8'd0, 8'd0, 8'd0});
    vecs[7] = mk(1, 0, 32'h0000_0000, 300, 2'b01, 2, 0, {32'h0, 32'h2000, 32'h0, 32'h0, 32'h0}, {8'd255, 8'd43, 8'd0, 8'd0, 8'd0});
    vecs[8] = mk(0, 3, 32'hFFFF_FFE0, 3, 2'b01, 2, 0, {32'hFFFF_FFE0, 32'h0, 32'h0, 32'h0, 32'h0}, {8'd0, 8'd1, 8'd0, 8'd0, 8'd0});
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(a_rdy), 64'd1);
    chk("rst_vld", 64'(a_vld), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_awaddr", 64'(a_awaddr), 64'd0);
    chk("rst_awlen", 64'(a_awlen), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) run(vecs[i]);
    sel = 1'b0;
    @(negedge clk);
    desc_chn_id = 2'd2;
    desc_addr = 32'h0;
    desc_beats = 16'd600;
    desc_burst = 2'b01;
    desc_vld = 1'b1;
    @(negedge clk);
    desc_vld = 1'b0;
    for (int b = 0; b < 2; b++) begin
      t = 0;
      while (!o_vld && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk("abort_vld", 64'(o_vld), 64'd1);
      if (b == 0) begin
        atx_rdy = 1'b1;
        @(negedge clk);
        atx_rdy = 1'b0;
      end
    end
    chk("abort_awaddr", 64'(o_awaddr), 64'h1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_vld_drop", 64'(o_vld), 64'd0);
    chk("abort_rdy", 64'(o_rdy), 64'd1);
    chk("abort_no_done", 64'(o_done), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet_done", 64'(o_done), 64'd0);
      chk("abort_quiet_vld", 64'(o_vld), 64'd0);
    end
    run(vecs[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adma_dm_wr_atx_gen.md
Name: adma_dm_wr_atx_gen

Overview:
Write-side burst generator that sits directly upstream of the write host stage (AW/W/B or AXIS master). It accepts one per-channel write descriptor (destination address, beat count, burst type) and splits it into legal AXI bursts, capped by the maximum burst length, the AXI 4KB boundary and the FIXED-burst 16-beat limit. Each burst is presented on the atx_* handshake consumed by the write host. It signals per-descriptor completion of issue; B-response completion is tracked downstream.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels
DST_IF_TYPE, "AXI4", "AXI4" or "AXIS"; "AXIS" disables 4KB splitting
DST_ADDR_W, 32, destination address width
MST_ID_W, 5, AXI ID width
ATX_LEN_W, 8, AxLEN width; max burst = 2^ATX_LEN_W beats
ATX_DST_DATA_W, 256, data width; ATX_DST_BYTE_AMT = ATX_DST_DATA_W/8
DESC_BEAT_W, 16, descriptor beat-count width
DMA_CHN_NUM_W, derived, (DMA_CHN_NUM>1) ? $clog2(DMA_CHN_NUM) : 1

Ports:
clk  in  1  clock
rst  in  1  reset
desc_chn_id  in  DMA_CHN_NUM_W  channel owning the descriptor
desc_addr  in  DST_ADDR_W  start byte address
desc_beats  in  DESC_BEAT_W  total beats; 0 is legal
desc_burst  in  2  01=INCR, 00=FIXED
desc_vld  in  1  descriptor valid
desc_rdy  out  1  descriptor ready
atx_id  in  MST_ID_W x DMA_CHN_NUM  per-channel AXI ID (unpacked [0:DMA_CHN_NUM-1])
atx_chn_id  out  DMA_CHN_NUM_W  burst channel
atx_awid  out  MST_ID_W  burst ID = atx_id[channel]
atx_awaddr  out  DST_ADDR_W  burst start address
atx_awlen  out  ATX_LEN_W  beats-1
atx_awburst  out  2  burst type
atx_vld  out  1  burst valid
atx_rdy  in  1  burst accepted by write host
desc_done  out  1  one-cycle pulse: last burst of descriptor issued
desc_done_chn_id  out  DMA_CHN_NUM_W  channel for desc_done
busy  out  1  descriptor in progress

Behaviour:
- Interface (already decided): one clock clk. rst is synchronous and active-high.
- Reset state: IDLE. desc_rdy=1. atx_vld, desc_done and busy = 0. All data outputs = 0.
- All outputs are registered. desc_rdy = (state==IDLE).
- FSM states:
  - IDLE: on desc_vld&desc_rdy, latch chn, addr with low log2(ATX_DST_BYTE_AMT) bits forced to 0, remaining=desc_beats, burst and awid. If desc_beats==0, next state is DONE; otherwise CALC. busy=1 from the next cycle.
  - CALC: one cycle. Compute burst beats n = min(remaining, 2^ATX_LEN_W, lim). For FIXED, lim=16. For INCR under AXI4, lim=(4096-addr[11:0])/ATX_DST_BYTE_AMT. For AXIS, lim is unbounded. Load atx_awaddr=addr and atx_awlen=n-1. Set atx_vld=1 and go to ISSUE.
  - ISSUE: hold all atx_* stable while atx_vld&!atx_rdy. On handshake: atx_vld=0; remaining -= n; addr += n*ATX_DST_BYTE_AMT for INCR, unchanged for FIXED. If remaining==0, go to DONE; otherwise CALC.
  - DONE: one cycle. desc_done=1 and desc_done_chn_id=chn; busy=0; go to IDLE.
- Latency: handshake at cycle N gives first atx_vld at N+2. Back-to-back bursts have 1 dead cycle (CALC). A zero-beat descriptor gives desc_done at N+1 and no atx_vld.
- Width rules:
  - remaining is DESC_BEAT_W bits; n is ATX_LEN_W+1 bits.
  - The address adder wraps modulo 2^DST_ADDR_W.
  - The 4KB limit uses addr[11:0] only and is always ≥1 beat.
- atx_vld never deasserts without atx_rdy. A new descriptor is not accepted until DONE completes.
- rst mid-burst aborts immediately: atx_vld drops the following cycle, no desc_done is issued, and all state is discarded.

Decomposition:
- Shared package adma_pkg: burst encodings (BURST_FIXED=2'b00, BURST_INCR=2'b01), constant AXI_4KB=4096, FSM state enum {IDLE,CALC,ISSUE,DONE}.
- One sub-module adma_dm_burst_calc: purely combinational n computation (remaining, addr, burst, params -> n). It is reused by the read side.

Test Plan:
- INCR, addr=0x1000, beats=4 -> one burst: awaddr=0x1000, awlen=3, awid=atx_id[chn], desc_done 1 cycle after the handshake.
- 4KB crossing, addr=0x0FC0, beats=8, 32B data -> bursts (0x0FC0, awlen=1) then (0x1000, awlen=5), then desc_done.
- Long INCR, addr=0x0, beats=600 -> 5 bursts: awlen 127,127,127,127,87 at 0x0, 0x1000, 0x2000, 0x3000, 0x4000.
- FIXED, addr=0x2000, beats=40 -> awlen 15,15,7, all at 0x2000; with DST_IF_TYPE="AXIS", INCR addr=0x0FC0, beats=8 -> a single burst, awlen=7.
- Backpressure: hold atx_rdy=0 for 5 cycles -> atx_vld and all fields stable. A descriptor with beats=0 -> desc_done with no atx_vld. Both checked via assertions.
- Assert rst during ISSUE of the 2nd burst -> atx_vld=0 next cycle, desc_rdy=1, no desc_done; a fresh descriptor then completes normally.
